uart_rx_periph: RTL and testbench

- Memory-mapped UART receiver peripheral; the receive-side counterpart of the core's UART transmit path.
- Deserialises 8N1 frames from the uart_rx pin and buffers bytes in a small FIFO.
- The RV32I core reads received bytes and status through its load path: lw/lbu to UART base + offset.
- Sits in riscv_ps_top beside the UART TX and shares the core's mem_addr / mem_data_rd_en bus.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_rx_fifo.sv | 50 +++++
 rtl/uart_rx_periph.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_periph.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive peripheral: register offsets,
// STATUS bit positions and the receiver FSM state encoding.
package uart_pkg;

    localparam logic [7:0] RXDATA_OFS = 8'h08;
    localparam logic [7:0] STATUS_OFS = 8'h0C;

    localparam int ST_NOT_EMPTY = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_FRAME_ERR = 2;
    localparam int ST_OVERRUN   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO with first-word fall-through head; a push while
// full is accepted only when a pop happens in the same cycle.
module uart_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           head,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             full;
    logic             empty;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_periph.sv
// Memory-mapped 8N1 UART receiver: synchroniser, bit-timing FSM, receive
// FIFO and a registered, OR-muxable read port for the core's load path.
module uart_rx_periph
    import uart_pkg::*;
#(
    parameter int          CLKS_PER_BIT = 87,
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [31:0] BASE_ADDR    = 32'h0050_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        uart_rx,
    input  logic [31:0] mem_addr,
    input  logic        mem_data_rd_en,
    output logic [31:0] mem_read_data,
    output logic        rx_irq
);

    localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] FULL_BIT  = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] HALF_BIT  = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [31:0] RXDATA_AD = BASE_ADDR + 32'(RXDATA_OFS);
    localparam logic [31:0] STATUS_AD = BASE_ADDR + 32'(STATUS_OFS);

    logic        sync1, sync2, sync3;
    logic        rx_s, fall;
    state_t      state, state_nx;
    logic [15:0] baud_cnt, baud_nx;
    logic [2:0]  bit_idx, bit_nx;
    logic [7:0]  shreg, shreg_nx;
    logic        push_req, ferr_set, ovr_set;
    logic        rd_data_sel, rd_stat_sel, pop;
    logic        overrun, frame_err, full, not_empty;
    logic [7:0]  head;
    logic [CW-1:0] count;
    logic [31:0] status;

    assign rx_s = sync2;
    assign fall = sync3 & ~sync2;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
        end else begin
            state    <= state_nx;
            baud_cnt <= baud_nx;
            bit_idx  <= bit_nx;
            shreg    <= shreg_nx;
        end
    end

    // Start is qualified at mid-bit; every later sample is one bit period on.
    always_comb begin
        state_nx = state;
        baud_nx  = baud_cnt;
        bit_nx   = bit_idx;
        shreg_nx = shreg;
        push_req = 1'b0;
        ferr_set = 1'b0;
        case (state)
            S_IDLE: begin
                if (fall) begin
                    baud_nx  = HALF_BIT;
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (baud_cnt != '0) begin
                    baud_nx = baud_cnt - 1'b1;
                end else if (rx_s) begin
                    state_nx = S_IDLE;
                end else begin
                    baud_nx  = FULL_BIT;
                    bit_nx   = '0;
                    state_nx = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_cnt != '0) begin
                    baud_nx = baud_cnt - 1'b1;
                end else begin
                    shreg_nx = {rx_s, shreg[7:1]};
                    baud_nx  = FULL_BIT;
                    bit_nx   = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nx = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_cnt != '0) begin
                    baud_nx = baud_cnt - 1'b1;
                end else begin
                    state_nx = S_IDLE;
                    push_req = rx_s;
                    ferr_set = ~rx_s;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    assign rd_data_sel = mem_data_rd_en && (mem_addr == RXDATA_AD);
    assign rd_stat_sel = mem_data_rd_en && (mem_addr == STATUS_AD);
    assign pop         = rd_data_sel & not_empty;
    assign not_empty   = (count != '0);
    assign full        = (count == CW'(FIFO_DEPTH));
    // A simultaneous pop frees a slot, so that push is not an overrun.
    assign ovr_set     = push_req & full & ~pop;

    uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_req),
        .push_data (shreg),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );

    always_comb begin
        status               = '0;
        status[ST_NOT_EMPTY] = not_empty;
        status[ST_FULL]      = full;
        status[ST_FRAME_ERR] = frame_err;
        status[ST_OVERRUN]   = overrun;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overrun       <= 1'b0;
            frame_err     <= 1'b0;
            mem_read_data <= '0;
            rx_irq        <= 1'b0;
        end else begin
            overrun   <= (overrun & ~rd_stat_sel) | ovr_set;
            frame_err <= (frame_err & ~rd_stat_sel) | ferr_set;
            rx_irq    <= not_empty;
            if (rd_data_sel)
                mem_read_data <= {24'b0, head & {8{not_empty}}};
            else if (rd_stat_sel)
                mem_read_data <= status;
            else
                mem_read_data <= '0;
        end
    end

endmodule

// File: tb/tb_uart_rx_periph.sv
// Directed bench for uart_rx_periph at CLKS_PER_BIT=16, FIFO_DEPTH=4:
// serial frames are driven on uart_rx and results read back over the bus.
module tb_uart_rx_periph;

    localparam logic [31:0] BASE = 32'h0050_0000;
    localparam logic [31:0] RXA  = BASE + 32'h8;
    localparam logic [31:0] STA  = BASE + 32'hC;
    localparam int          CPB  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        uart_rx;
    logic [31:0] mem_addr;
    logic        mem_data_rd_en;
    logic [31:0] mem_read_data;
    logic        rx_irq;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_periph #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .uart_rx        (uart_rx),
        .mem_addr       (mem_addr),
        .mem_data_rd_en (mem_data_rd_en),
        .mem_read_data  (mem_read_data),
        .rx_irq         (rx_irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called on a negedge; returns on the negedge after the strobe cycle.
    task automatic rd(input logic [31:0] addr, output logic [31:0] data);
        mem_addr       = addr;
        mem_data_rd_en = 1'b1;
        @(negedge clk);
        mem_data_rd_en = 1'b0;
        data           = mem_read_data;
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        rd(addr, d);
        chk(tag, d, exp);
    endtask

    task automatic send_head(input logic [7:0] b);
        uart_rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            wait_cyc(CPB);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop);
        send_head(b);
        uart_rx = stop;
        wait_cyc(CPB);
        uart_rx = 1'b1;
    endtask

    initial begin
        logic [7:0] hello [5];
        hello = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F};

        rst_n          = 1'b0;
        uart_rx        = 1'b1;
        mem_addr       = '0;
        mem_data_rd_en = 1'b0;
        wait_cyc(3);
        chk("reset_rdata", mem_read_data, 32'h0);
        chk("reset_irq", {31'b0, rx_irq}, 32'h0);
        rst_n = 1'b1;
        wait_cyc(3);
        rd_chk("reset_status", STA, 32'h0);

        // 1: single byte, irq timing around the mid-stop sample
        send_head(8'h48);
        uart_rx = 1'b1;
        wait_cyc(9);
        chk("t1_irq_before_stop", {31'b0, rx_irq}, 32'h0);
        wait_cyc(4);
        chk("t1_irq_after_stop", {31'b0, rx_irq}, 32'h1);
        wait_cyc(3);
        rd_chk("t1_status", STA, 32'h1);
        @(negedge clk);
        chk("t1_rdata_hold_1cyc", mem_read_data, 32'h0);
        rd_chk("t1_unmapped", BASE + 32'h4, 32'h0);
        rd_chk("t1_rxdata", RXA, 32'h48);
        rd_chk("t1_status_after", STA, 32'h0);

        // 2: "Hello" back to back; the first byte is read during the 5th frame
        for (int i = 0; i < 4; i++) send_frame(hello[i], 1'b1);
        fork
            send_frame(hello[4], 1'b1);
            begin
                rd_chk("t2_status_full", STA, 32'h3);
                rd_chk("t2_rx0", RXA, 32'h48);
            end
        join
        for (int i = 1; i < 5; i++) rd_chk("t2_rx", RXA, {24'b0, hello[i]});
        rd_chk("t2_status_empty", STA, 32'h0);

        // 3: overrun on the 5th byte
        for (int i = 0; i < 5; i++) send_frame(8'h10 + 8'(i), 1'b1);
        wait_cyc(2);
        rd_chk("t3_status_ovr", STA, 32'hB);
        rd_chk("t3_status_cleared", STA, 32'h3);
        for (int i = 0; i < 4; i++) rd_chk("t3_rx", RXA, 32'h10 + 32'(i));
        rd_chk("t3_status_empty", STA, 32'h0);

        // Pop coinciding with the push of a 5th byte while full
        for (int i = 0; i < 4; i++) send_frame(8'h21 + 8'(i), 1'b1);
        fork
            send_frame(8'h25, 1'b1);
            begin
                wait_cyc(154);
                rd_chk("tpp_rx0", RXA, 32'h21);
            end
        join
        wait_cyc(2);
        rd_chk("tpp_status", STA, 32'h3);
        for (int i = 0; i < 4; i++) rd_chk("tpp_rx", RXA, 32'h22 + 32'(i));

        // 4: framing error
        send_frame(8'h55, 1'b0);
        wait_cyc(20);
        rd_chk("t4_status_ferr", STA, 32'h4);
        rd_chk("t4_rxdata_empty", RXA, 32'h0);
        rd_chk("t4_status_cleared", STA, 32'h0);

        // 5: short glitch on an idle line
        uart_rx = 1'b0;
        wait_cyc(3);
        uart_rx = 1'b1;
        wait_cyc(40);
        rd_chk("t5_status", STA, 32'h0);
        chk("t5_irq", {31'b0, rx_irq}, 32'h0);

        // 6: reset mid-frame with a byte already buffered
        send_frame(8'h11, 1'b1);
        wait_cyc(2);
        chk("t6_irq_pre", {31'b0, rx_irq}, 32'h1);
        uart_rx = 1'b0;
        wait_cyc(CPB);
        uart_rx = 1'b1;
        wait_cyc(CPB);
        uart_rx = 1'b0;
        wait_cyc(CPB);
        rst_n          = 1'b0;
        mem_addr       = STA;
        mem_data_rd_en = 1'b1;
        wait_cyc(2);
        chk("t6_rdata_in_reset", mem_read_data, 32'h0);
        chk("t6_irq_in_reset", {31'b0, rx_irq}, 32'h0);
        mem_data_rd_en = 1'b0;
        uart_rx        = 1'b1;
        rst_n          = 1'b1;
        wait_cyc(40);
        send_frame(8'hA5, 1'b1);
        wait_cyc(2);
        chk("t6_irq_post", {31'b0, rx_irq}, 32'h1);
        rd_chk("t6_status", STA, 32'h1);
        rd_chk("t6_rxdata", RXA, 32'hA5);
        rd_chk("t6_status_empty", STA, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
